// File: rtl/mpu_pkg.sv
// Shared constants, bank-state encoding and row packing helper for the MPU transpose stream.
package mpu_pkg;

  localparam int unsigned MPU_N = 5;
  localparam int unsigned MPU_W = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_LOADING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // LSB position of column col inside a packed row of width-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned col, input int unsigned width);
    return col * width;
  endfunction

endpackage

// File: rtl/mpu_matrix_bank.sv
// One N x N register bank: row write port, row/column read mux, load/drain state and stored mode.
module mpu_matrix_bank
  import mpu_pkg::*;
#(
  parameter int unsigned N = MPU_N,
  parameter int unsigned W = MPU_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en_i,
  input  logic [N*W-1:0] wr_row_i,
  input  logic           wr_mode_i,
  input  logic           rd_en_i,
  output logic           full_o,
  output logic           empty_o,
  output logic           wr_last_o,
  output logic [N*W-1:0] rd_row_o,
  output logic           rd_last_o
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef logic [N-1:0][W-1:0] row_t;

  bank_state_e   state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          mode_q, mode_d;
  row_t          mem_q [N];

  assign wr_last_o = (wr_cnt_q == LAST_IDX);
  assign rd_last_o = (rd_cnt_q == LAST_IDX);
  assign full_o    = (state_q == BANK_FULL);
  assign empty_o   = (state_q == BANK_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BANK_EMPTY;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      mode_q   <= mode_d;
    end
  end

  // Load fills rows in order; drain walks rd_cnt until the last row releases the bank.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    mode_d   = mode_q;
    if (wr_en_i && (wr_cnt_q == '0)) mode_d = wr_mode_i;
    case (state_q)
      BANK_EMPTY, BANK_LOADING: begin
        if (wr_en_i) begin
          if (wr_last_o) begin
            state_d  = BANK_FULL;
            wr_cnt_d = '0;
          end else begin
            state_d  = BANK_LOADING;
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      BANK_FULL: begin
        if (rd_en_i) begin
          if (rd_last_o) begin
            state_d  = BANK_EMPTY;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en_i) begin
      mem_q[wr_cnt_q] <= row_t'(wr_row_i);
    end
  end

  // Transpose reads column rd_cnt down all rows; pass-through reads row rd_cnt.
  for (genvar c = 0; c < N; c++) begin : g_rd
    assign rd_row_o[elem_lsb(c, W) +: W] = mode_q ? mem_q[c][rd_cnt_q] : mem_q[rd_cnt_q][c];
  end

endmodule

// File: rtl/mpu_transpose_stream.sv
// Streaming N x N transpose/pass-through unit. Define MPU_TRANSPOSE_PINGPONG_EN for two
// alternating banks (load one while draining the other); otherwise a single bank is used.
module mpu_transpose_stream
  import mpu_pkg::*;
#(
  parameter int unsigned N = MPU_N,
  parameter int unsigned W = MPU_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  input  logic           in_transpose,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic           out_last,
  output logic           busy
);

`ifdef MPU_TRANSPOSE_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif

  logic [NB-1:0]  wr_en, rd_en, full, empty, wr_last, rd_last;
  logic [N*W-1:0] rd_row [NB];
  logic           wr_sel, rd_sel;
  logic           in_fire, out_fire;

  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_row   = rd_row[rd_sel];
  assign out_last  = out_valid & rd_last[rd_sel];
  assign busy      = ~(&empty);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign wr_en[b] = in_fire & (wr_sel == 1'(b));
    assign rd_en[b] = out_fire & (rd_sel == 1'(b));

    mpu_matrix_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en[b]),
      .wr_row_i  (in_row),
      .wr_mode_i (in_transpose),
      .rd_en_i   (rd_en[b]),
      .full_o    (full[b]),
      .empty_o   (empty[b]),
      .wr_last_o (wr_last[b]),
      .rd_row_o  (rd_row[b]),
      .rd_last_o (rd_last[b])
    );
  end

`ifdef MPU_TRANSPOSE_PINGPONG_EN
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Each pointer flips independently on its own final-row handshake, so both may flip together.
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (in_fire && wr_last[wr_sel_q])  wr_sel_d = ~wr_sel_q;
    if (out_fire && rd_last[rd_sel_q]) rd_sel_d = ~rd_sel_q;
  end

  assign wr_sel = wr_sel_q;
  assign rd_sel = rd_sel_q;
`else
  logic unused_wr_last;

  assign wr_sel         = 1'b0;
  assign rd_sel         = 1'b0;
  assign unused_wr_last = wr_last[0];
`endif

endmodule
